// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, instruction-memory req/ack handshake and instruction register.
// Define PREFETCH_BUF_EN to overlap fetches using a one-entry skid buffer.
module instr_fetch_unit #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic              CLOCK,
  input  logic              RESETN,
  output logic              MEM_REQ,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic              MEM_ACK,
  input  logic [15:0]       MEM_RDATA,
  input  logic              STALL,
  input  logic              BRANCH,
  input  logic [ADDR_W-1:0] BRANCH_TARGET,
  output logic [15:0]       INSTR,
  output logic              INSTR_VALID,
  output logic [ADDR_W-1:0] PC_OUT
);

  localparam int unsigned       INSTR_W = 16;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_e;

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic                 mem_req_q, mem_req_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic [ADDR_W-1:0]    pc_out_q, pc_out_d;
  logic                 discard_q, discard_d;
`ifdef PREFETCH_BUF_EN
  logic [INSTR_W-1:0]   skid_q, skid_d;
  logic [ADDR_W-1:0]    skid_pc_q, skid_pc_d;
  logic                 skid_valid_q, skid_valid_d;
`endif

  logic ack_c;
  logic consume_c;

  assign ack_c     = MEM_ACK & mem_req_q;
  assign consume_c = instr_valid_q & ~STALL;

  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      mem_addr_q    <= RESET_PC;
      mem_req_q     <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      pc_out_q      <= '0;
      discard_q     <= 1'b0;
`ifdef PREFETCH_BUF_EN
      skid_q        <= '0;
      skid_pc_q     <= '0;
      skid_valid_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      mem_addr_q    <= mem_addr_d;
      mem_req_q     <= mem_req_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      pc_out_q      <= pc_out_d;
      discard_q     <= discard_d;
`ifdef PREFETCH_BUF_EN
      skid_q        <= skid_d;
      skid_pc_q     <= skid_pc_d;
      skid_valid_q  <= skid_valid_d;
`endif
    end
  end

  // Invariant: while a request is outstanding and no redirect is pending, pc_q == mem_addr_q.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    mem_addr_d    = mem_addr_q;
    mem_req_d     = mem_req_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    pc_out_d      = pc_out_q;
    discard_d     = discard_q;
`ifdef PREFETCH_BUF_EN
    skid_d        = skid_q;
    skid_pc_d     = skid_pc_q;
    skid_valid_d  = skid_valid_q;
`endif
    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        mem_addr_d = pc_q;
        mem_req_d  = 1'b1;
      end
      S_FETCH: begin
        if (BRANCH) begin
          pc_d          = BRANCH_TARGET;
          instr_valid_d = 1'b0;
          if (ack_c) begin
            mem_addr_d = BRANCH_TARGET;
            discard_d  = 1'b0;
          end else begin
            discard_d  = 1'b1;
          end
        end else if (ack_c) begin
          if (discard_q) begin
            discard_d  = 1'b0;
            mem_addr_d = pc_q;
          end else begin
            instr_d       = MEM_RDATA;
            pc_out_d      = mem_addr_q;
            instr_valid_d = 1'b1;
            pc_d          = pc_q + STEP;
            state_d       = S_VALID;
`ifdef PREFETCH_BUF_EN
            mem_addr_d    = pc_q + STEP;
`else
            mem_req_d     = 1'b0;
`endif
          end
        end
      end
      S_VALID: begin
        if (BRANCH) begin
          pc_d          = BRANCH_TARGET;
          instr_valid_d = 1'b0;
          mem_req_d     = 1'b1;
          state_d       = S_FETCH;
`ifdef PREFETCH_BUF_EN
          skid_valid_d  = 1'b0;
          if (mem_req_q && !MEM_ACK) discard_d = 1'b1;
          else                       mem_addr_d = BRANCH_TARGET;
`else
          mem_addr_d    = BRANCH_TARGET;
`endif
        end else if (consume_c) begin
`ifdef PREFETCH_BUF_EN
          if (skid_valid_q) begin
            instr_d      = skid_q;
            pc_out_d     = skid_pc_q;
            skid_valid_d = 1'b0;
            mem_addr_d   = pc_q;
            mem_req_d    = 1'b1;
          end else if (ack_c) begin
            instr_d    = MEM_RDATA;
            pc_out_d   = mem_addr_q;
            pc_d       = pc_q + STEP;
            mem_addr_d = pc_q + STEP;
          end else begin
            // Prefetch still in flight: wait for it in FETCH.
            instr_valid_d = 1'b0;
            state_d       = S_FETCH;
          end
`else
          instr_valid_d = 1'b0;
          mem_addr_d    = pc_q;
          mem_req_d     = 1'b1;
          state_d       = S_FETCH;
`endif
        end
`ifdef PREFETCH_BUF_EN
        else if (ack_c) begin
          skid_d       = MEM_RDATA;
          skid_pc_d    = mem_addr_q;
          skid_valid_d = 1'b1;
          pc_d         = pc_q + STEP;
          mem_req_d    = 1'b0;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign MEM_REQ     = mem_req_q;
  assign MEM_ADDR    = mem_addr_q;
  assign INSTR       = instr_q;
  assign INSTR_VALID = instr_valid_q;
  assign PC_OUT      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a stream-level model checked every cycle.
// Build with PREFETCH_BUF_EN defined to exercise the skid-buffer variant.
module tb_instr_fetch_unit;

  logic        CLOCK;
  logic        RESETN;
  logic        MEM_REQ;
  logic [15:0] MEM_ADDR;
  logic        MEM_ACK;
  logic [15:0] MEM_RDATA;
  logic        STALL;
  logic        BRANCH;
  logic [15:0] BRANCH_TARGET;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic [15:0] PC_OUT;

  int n_tests = 0;
  int n_fail  = 0;
  int lat     = 0;
  int wait_cnt;

  instr_fetch_unit dut (
    .CLOCK(CLOCK), .RESETN(RESETN),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA),
    .STALL(STALL), .BRANCH(BRANCH), .BRANCH_TARGET(BRANCH_TARGET),
    .INSTR(INSTR), .INSTR_VALID(INSTR_VALID), .PC_OUT(PC_OUT)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0000) return 16'h0800;
    if (a == 16'h0001) return 16'h2345;
    return a ^ 16'hC3A5;
  endfunction

  // Memory: acknowledges once a request has waited 'lat' cycles (lat=0 is zero-wait).
  always_ff @(posedge CLOCK or negedge RESETN) begin
    if (!RESETN)                 wait_cnt <= 0;
    else if (MEM_REQ && !MEM_ACK) wait_cnt <= wait_cnt + 1;
    else                         wait_cnt <= 0;
  end
  assign MEM_ACK   = MEM_REQ && (wait_cnt >= lat);
  assign MEM_RDATA = mem_word(MEM_ADDR);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  // Stream model: delivered PCs follow RESET_PC, +1 per consume, jump to target on branch.
  logic [15:0] exp_pc;
  logic        have_prev;
  logic        p_branch, p_consume, p_hold, p_wait;
  logic [15:0] p_target, p_instr, p_pcout, p_addr;

  always @(negedge CLOCK) begin
    if (!RESETN) begin
      exp_pc    = 16'h0000;
      have_prev = 1'b0;
    end else begin
      if (have_prev) begin
        if (p_branch)       exp_pc = p_target;
        else if (p_consume) exp_pc = exp_pc + 16'd1;
        if (p_branch) check("mon_branch_flush", 32'(INSTR_VALID), 32'd0);
        if (p_hold) begin
          check("mon_hold_valid", 32'(INSTR_VALID), 32'd1);
          check("mon_hold_instr", 32'(INSTR), 32'(p_instr));
          check("mon_hold_pc", 32'(PC_OUT), 32'(p_pcout));
        end
        if (p_wait) begin
          check("mon_req_held", 32'(MEM_REQ), 32'd1);
          check("mon_addr_stable", 32'(MEM_ADDR), 32'(p_addr));
        end
      end
      if (INSTR_VALID) begin
        check("mon_pc_seq", 32'(PC_OUT), 32'(exp_pc));
        check("mon_instr_data", 32'(INSTR), 32'(mem_word(PC_OUT)));
      end
      have_prev = 1'b1;
      p_branch  = BRANCH;
      p_target  = BRANCH_TARGET;
      p_consume = INSTR_VALID && !STALL && !BRANCH;
      p_hold    = INSTR_VALID && STALL && !BRANCH;
      p_wait    = MEM_REQ && !MEM_ACK;
      p_instr   = INSTR;
      p_pcout   = PC_OUT;
      p_addr    = MEM_ADDR;
    end
  end

  logic [15:0] stall_pat;

  initial begin
    STALL = 1'b0; BRANCH = 1'b0; BRANCH_TARGET = 16'h0000;
    stall_pat = 16'b0011_0100_1100_0010;
    RESETN = 1'b1;
    #1 RESETN = 1'b0;
    #2;
    check("rst_req", 32'(MEM_REQ), 32'd0);
    check("rst_addr", 32'(MEM_ADDR), 32'h0);
    check("rst_instr", 32'(INSTR), 32'h0);
    check("rst_valid", 32'(INSTR_VALID), 32'd0);
    check("rst_pcout", 32'(PC_OUT), 32'h0);
    @(posedge CLOCK); #1;
    RESETN = 1'b1;

    // 1: zero-wait stream from reset
    tick();
    check("t1_req0", 32'(MEM_REQ), 32'd1);
    check("t1_addr0", 32'(MEM_ADDR), 32'h0);
    tick();
    check("t1_instr0", 32'(INSTR), 32'h0800);
    check("t1_pc0", 32'(PC_OUT), 32'h0);
    check("t1_valid0", 32'(INSTR_VALID), 32'd1);
`ifdef PREFETCH_BUF_EN
    check("t1_addr1", 32'(MEM_ADDR), 32'h1);
    tick();
`else
    tick();
    check("t1_gap", 32'(INSTR_VALID), 32'd0);
    check("t1_addr1", 32'(MEM_ADDR), 32'h1);
    tick();
`endif
    check("t1_instr1", 32'(INSTR), 32'h2345);
    check("t1_pc1", 32'(PC_OUT), 32'h1);
    check("t1_valid1", 32'(INSTR_VALID), 32'd1);

    // 2: stall holds the instruction and issues no new request
    STALL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_instr", 32'(INSTR), 32'h2345);
      check("t2_pc", 32'(PC_OUT), 32'h1);
      check("t2_noreq", 32'(MEM_REQ), 32'd0);
    end
    STALL = 1'b0;
    tick();
`ifdef PREFETCH_BUF_EN
    check("t2_skid_instr", 32'(INSTR), 32'hC3A7);
    check("t2_skid_pc", 32'(PC_OUT), 32'h2);
    check("t2_next_addr", 32'(MEM_ADDR), 32'h3);
`else
    check("t2_next_req", 32'(MEM_REQ), 32'd1);
    check("t2_next_addr", 32'(MEM_ADDR), 32'h2);
`endif

    // 3: branch during a 3-cycle memory wait drops the returning word
    RESETN = 1'b0;
    lat = 2;
    @(posedge CLOCK); #1;
    RESETN = 1'b1;
    tick();
    check("t3_req", 32'(MEM_REQ), 32'd1);
    check("t3_addr_c1", 32'(MEM_ADDR), 32'h0);
    tick();
    check("t3_addr_c2", 32'(MEM_ADDR), 32'h0);
    BRANCH = 1'b1; BRANCH_TARGET = 16'h0040;
    tick();
    BRANCH = 1'b0;
    check("t3_addr_c3", 32'(MEM_ADDR), 32'h0);
    check("t3_valid_c3", 32'(INSTR_VALID), 32'd0);
    tick();
    check("t3_dropped", 32'(INSTR_VALID), 32'd0);
    check("t3_target_addr", 32'(MEM_ADDR), 32'h0040);
    check("t3_target_req", 32'(MEM_REQ), 32'd1);
    tick();
    tick();
    check("t3_wait_valid", 32'(INSTR_VALID), 32'd0);
    tick();
    check("t3_instr", 32'(INSTR), 32'hC3E5);
    check("t3_pc", 32'(PC_OUT), 32'h0040);
    check("t3_valid", 32'(INSTR_VALID), 32'd1);

    // 4: branch wins over stall
    lat = 0;
    STALL = 1'b1; BRANCH = 1'b1; BRANCH_TARGET = 16'hFFFF;
    tick();
    BRANCH = 1'b0; STALL = 1'b0;
    check("t4_valid", 32'(INSTR_VALID), 32'd0);
    check("t4_addr", 32'(MEM_ADDR), 32'hFFFF);
    check("t4_req", 32'(MEM_REQ), 32'd1);

    // 5: PC wraps from FFFF to 0000
    tick();
    check("t5_pc_ffff", 32'(PC_OUT), 32'hFFFF);
    check("t5_instr_ffff", 32'(INSTR), 32'h3C5A);
`ifndef PREFETCH_BUF_EN
    tick();
    check("t5_wrap_addr", 32'(MEM_ADDR), 32'h0000);
`endif
    tick();
    check("t5_pc_wrap", 32'(PC_OUT), 32'h0000);
    check("t5_instr_wrap", 32'(INSTR), 32'h0800);

    // 6: asynchronous reset in the middle of a request
    lat = 100;
`ifdef PREFETCH_BUF_EN
    STALL = 1'b1;
    #1;
    check("t6_pre_valid", 32'(INSTR_VALID), 32'd1);
`else
    tick();
`endif
    check("t6_pre_req", 32'(MEM_REQ), 32'd1);
    #2 RESETN = 1'b0;
    #1;
    check("t6_req_clr", 32'(MEM_REQ), 32'd0);
    check("t6_valid_clr", 32'(INSTR_VALID), 32'd0);
    check("t6_instr_clr", 32'(INSTR), 32'h0);
    check("t6_pc_clr", 32'(PC_OUT), 32'h0);
    @(posedge CLOCK); #1;
    RESETN = 1'b1; lat = 0; STALL = 1'b0;
    tick();
    check("t6_first_req", 32'(MEM_REQ), 32'd1);
    check("t6_first_addr", 32'(MEM_ADDR), 32'h0);
    tick();
    check("t6_first_instr", 32'(INSTR), 32'h0800);

    // Mixed stalls, latencies and redirects, checked by the stream model
    for (int i = 0; i < 64; i++) begin
      STALL  = stall_pat[i % 16];
      lat    = i % 3;
      BRANCH = (i == 25) || (i == 41);
      BRANCH_TARGET = (i == 25) ? 16'h0100 : 16'hFFFE;
      tick();
    end
    BRANCH = 1'b0; STALL = 1'b0;
    repeat (6) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Fetch stage of the 16-bit core. It owns the program counter, runs a request/acknowledge handshake to instruction memory, and holds the fetched word in an instruction register. That register drives INSTR of the combinational ALU/control decoder directly downstream. The execute stage supplies stall and branch-redirect inputs.

Parameters:
ADDR_W, 16, PC/memory address width
RESET_PC, 16'h0000, PC value loaded on reset
PC_STEP, 1, PC increment per fetched word (word-addressed memory)

Ports:
CLOCK  input  1  single clock, rising edge
RESETN  input  1  asynchronous active-low reset
MEM_REQ  output  1  fetch request to instruction memory
MEM_ADDR  output  ADDR_W  fetch address, stable while MEM_REQ high
MEM_ACK  input  1  memory completes the request this cycle
MEM_RDATA  input  16  instruction word, valid in the MEM_ACK cycle
STALL  input  1  downstream cannot accept INSTR this cycle
BRANCH  input  1  redirect: flush and fetch from BRANCH_TARGET
BRANCH_TARGET  input  ADDR_W  redirect address
INSTR  output  16  instruction register, feeds decoder INSTR
INSTR_VALID  output  1  INSTR holds a live instruction
PC_OUT  output  ADDR_W  address INSTR was fetched from

Behaviour:
- One clock (CLOCK). Reset is asynchronous, active-low (RESETN). All state clears immediately on RESETN low.
- Reset values: MEM_REQ=0, MEM_ADDR=RESET_PC, INSTR=16'h0000, INSTR_VALID=0, PC_OUT=0, PC=RESET_PC, state IDLE, discard flag 0.
- Reset mid-request drops MEM_REQ combinationally with the reset. Memory must tolerate the abandoned request.
- Handshake:
  - MEM_REQ and MEM_ADDR are registered.
  - Once MEM_REQ is high, MEM_ADDR holds until MEM_ACK is sampled high.
  - MEM_ACK may arrive in the first MEM_REQ cycle (zero-wait memory).
  - MEM_REQ may stay high across back-to-back requests with a new MEM_ADDR after each ACK.
- Consume: INSTR is consumed on any edge where INSTR_VALID=1 and STALL=0.
- States:
  - IDLE: the cycle after reset release. Go to FETCH, MEM_ADDR<=PC, MEM_REQ<=1.
  - FETCH: request outstanding.
    - On ACK with discard flag 0 and BRANCH=0: INSTR<=MEM_RDATA, PC_OUT<=MEM_ADDR, INSTR_VALID<=1, PC<=PC+PC_STEP, MEM_REQ<=0, go to VALID.
    - On ACK with discard=1: drop data, clear discard, MEM_ADDR<=PC, stay FETCH with MEM_REQ high.
  - VALID: INSTR_VALID=1.
    - On consume: INSTR_VALID<=0, MEM_ADDR<=PC, MEM_REQ<=1, go to FETCH.
    - While STALL=1: hold everything.
- BRANCH has highest priority in every state except IDLE:
  - PC<=BRANCH_TARGET and INSTR_VALID<=0.
  - If a request is outstanding and not acked this cycle, set discard; the returning word is dropped.
  - If acked this cycle, drop the word and issue the target request next.
  - From VALID, go to FETCH with MEM_ADDR<=BRANCH_TARGET regardless of STALL.
- BRANCH and STALL together: BRANCH wins.
- PC arithmetic is modulo 2^ADDR_W; 16'hFFFF+1 wraps to 16'h0000.
- Base throughput: one instruction per 2 cycles with zero-wait memory.

Optional Feature:
PREFETCH_BUF_EN
- Defined:
  - In VALID, the unit keeps requesting PC+PC_STEP in parallel with the held instruction.
  - An ACK coinciding with a consume loads INSTR directly.
  - Otherwise the word goes into a one-entry skid buffer (SKID, SKID_PC, SKID_VALID).
  - No new request is issued while SKID_VALID=1.
  - On consume with SKID_VALID=1: INSTR<=SKID, PC_OUT<=SKID_PC.
  - BRANCH clears INSTR_VALID and SKID_VALID and sets discard for any outstanding request.
  - Throughput: 1 instruction/cycle with zero-wait memory.
- Undefined: no skid buffer; base 2-cycle behaviour only.

Test Plan:
1. Reset release with RESET_PC=0, memory zero-wait returning 16'h0800 at addr 0 and 16'h2345 at addr 1, STALL=0 -> MEM_ADDR 0 then 1; INSTR=16'h0800 with PC_OUT=0, then 16'h2345 with PC_OUT=1; INSTR_VALID spacing 2 cycles (1 cycle with PREFETCH_BUF_EN).
2. STALL held 5 cycles while INSTR_VALID=1 -> INSTR and PC_OUT unchanged, no new MEM_REQ rising edge (base build); release -> next fetch issued the following cycle.
3. Memory with 3-cycle ACK latency, BRANCH to 16'h0040 in the second wait cycle -> MEM_ADDR stable until ACK, returned word dropped (INSTR_VALID stays 0), next MEM_ADDR=16'h0040.
4. BRANCH and STALL asserted together with INSTR_VALID=1 -> INSTR_VALID=0 next cycle, fetch from BRANCH_TARGET.
5. BRANCH_TARGET=16'hFFFF, two sequential fetches -> PC_OUT=16'hFFFF then 16'h0000.
6. RESETN pulsed low mid-request (MEM_REQ=1, INSTR_VALID=1) -> MEM_REQ, INSTR_VALID, INSTR clear immediately without a clock edge; after release, first MEM_ADDR=RESET_PC.
